// File: rtl/hs_rr_arbiter.sv
// hs_rr_arbiter: round-robin arbiter that merges N_CH valid/ready burst channels into one registered output
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          per-channel handshake
//   in_data/in_addr            per-channel payload, channel c at [c*W +: W]
//   in_last                    per-channel end-of-burst marker
//   grant                      one-hot current owner, zero while arbitrating
//   out_valid/out_ready        output handshake
//   out_data/out_addr/out_last registered beat
//   out_ch                     source channel of the registered beat
module hs_rr_arbiter #(
    parameter int N_CH      = 4,
    parameter int D_WIDTH   = 32,
    parameter int A_WIDTH   = 8,
    parameter int MAX_BEATS = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_CH-1:0]            in_valid,
    output logic [N_CH-1:0]            in_ready,
    input  logic [N_CH*D_WIDTH-1:0]    in_data,
    input  logic [N_CH*A_WIDTH-1:0]    in_addr,
    input  logic [N_CH-1:0]            in_last,
    output logic [N_CH-1:0]            grant,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [D_WIDTH-1:0]         out_data,
    output logic [A_WIDTH-1:0]         out_addr,
    output logic                       out_last,
    output logic [$clog2(N_CH)-1:0]    out_ch
);
    localparam int CW = $clog2(N_CH);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] OWN  = 1'b1;

    logic [0:0]    state;
    logic          armed;
    logic [CW-1:0] ptr;
    logic [CW-1:0] sel;
    logic [CW-1:0] idx;
    logic          found;
    logic [7:0]    cnt;
    logic          ch_xfer;
    logic          exit_now;

    // First valid channel searching upward from ptr+1, wrapping modulo N_CH
    always_comb begin
        sel   = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            idx = CW'((int'(ptr) + i) % N_CH);
            if (!found && in_valid[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign in_ready = grant & {N_CH{!out_valid || out_ready}};
    assign ch_xfer  = |(in_valid & in_ready);
    assign exit_now = in_last[ptr] || (({1'b0, cnt} + 9'd1) == 9'(MAX_BEATS));

    // armed holds off arbitration for one cycle after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            armed <= 1'b0;
            grant <= '0;
            ptr   <= CW'(N_CH - 1);
            cnt   <= '0;
        end else begin
            armed <= 1'b1;
            if (state == IDLE) begin
                if (armed && found) begin
                    state      <= OWN;
                    grant      <= '0;
                    grant[sel] <= 1'b1;
                    ptr        <= sel;
                    cnt        <= '0;
                end
            end else if (ch_xfer) begin
                cnt <= cnt + 8'd1;
                if (exit_now) begin
                    state <= IDLE;
                    grant <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_last  <= 1'b0;
            out_ch    <= '0;
        end else if (ch_xfer) begin
            out_valid <= 1'b1;
            out_data  <= in_data[ptr*D_WIDTH +: D_WIDTH];
            out_addr  <= in_addr[ptr*A_WIDTH +: A_WIDTH];
            out_last  <= in_last[ptr];
            out_ch    <= ptr;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_hs_rr_arbiter.sv
// tb_hs_rr_arbiter: randomized scoreboard bench for hs_rr_arbiter
module tb_hs_rr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int MB = 4;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N*AW-1:0] in_addr;
    logic [N-1:0]    in_last;
    logic [N-1:0]    grant;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [DW-1:0]   out_data;
    logic [AW-1:0]   out_addr;
    logic            out_last;
    logic [CW-1:0]   out_ch;

    hs_rr_arbiter #(.N_CH(N), .D_WIDTH(DW), .A_WIDTH(AW), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .in_last(in_last), .grant(grant),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .out_last(out_last), .out_ch(out_ch)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    logic [DW-1:0] d[N] = '{default: '0};
    logic [AW-1:0] a[N] = '{default: '0};
    logic [N-1:0]  v = '0;
    logic [N-1:0]  l = '0;
    logic [N-1:0]  xfer_seen = '0;
    int            mode = 0;

    always_comb begin
        in_data  = '0;
        in_addr  = '0;
        for (int c = 0; c < N; c++) begin
            in_data[c*DW +: DW] = d[c];
            in_addr[c*AW +: AW] = a[c];
        end
        in_valid = v;
        in_last  = l;
    end

    // Modes: 0 all valid single-beat bursts, 1 random, 2 all valid held, 3 random with output stalled, 4 idle drain
    initial forever begin
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (mode == 4) v[c] = 1'b0;
            else if (mode == 2) v[c] = 1'b1;
            else if (xfer_seen[c] || !v[c]) begin
                if (xfer_seen[c]) begin
                    d[c] = $urandom;
                    a[c] = AW'($urandom);
                end
                l[c] = (mode == 0) ? 1'b1 : ($urandom_range(7) == 0);
                v[c] = (mode == 0) ? 1'b1 : (xfer_seen[c] ? ($urandom_range(9) < 7) : ($urandom_range(2) == 0));
            end
        end
        out_ready = (mode == 3) ? 1'b0 : (mode == 1) ? ($urandom_range(3) != 0) : 1'b1;
    end

    typedef struct {
        logic [CW-1:0] ch;
        logic [DW-1:0] dd;
        logic [AW-1:0] aa;
        logic          ll;
    } beat_t;

    beat_t        q[$];
    beat_t        e;
    logic [42:0]  held;
    logic         hold_v;
    logic [N-1:0] prev_grant;
    logic [N-1:0] prev_valid;
    logic         exit_pend;
    int           last_owner;
    int           beats;
    int           rel;
    int           pick;
    int           src;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            q.delete();
            last_owner = N - 1;
            prev_grant = '0;
            prev_valid = '0;
            exit_pend  = 1'b0;
            hold_v     = 1'b0;
            beats      = 0;
            rel        = 0;
            xfer_seen  = '0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(grant & {N{!out_valid || out_ready}}));
            chk("grant_onehot0", 64'($onehot0(grant)), 64'(1));
            if (hold_v) begin
                chk("hold_valid", 64'(out_valid), 64'(1));
                chk("hold_stable", 64'({out_ch, out_addr, out_last, out_data}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_beat: got unexpected beat ch%0d data %0h, expected none", out_ch, out_data);
                end else begin
                    e = q.pop_front();
                    chk("out_beat", 64'({out_ch, out_addr, out_last, out_data}), 64'({e.ch, e.aa, e.ll, e.dd}));
                end
            end
            hold_v = out_valid && !out_ready;
            held   = {out_ch, out_addr, out_last, out_data};
            if (rel == 1) chk("first_grant_delay", 64'(grant), 64'(0));
            if (prev_grant != 0) begin
                chk("burst_exit", 64'(grant == 0), 64'(exit_pend));
                if (grant != 0) chk("grant_held", 64'(grant), 64'(prev_grant));
            end else if (grant != 0) begin
                pick = -1;
                for (int i = 1; i <= N; i++)
                    if (pick < 0 && prev_valid[(last_owner + i) % N]) pick = (last_owner + i) % N;
                chk("arb_pick", 64'(grant), (pick < 0) ? 64'(0) : (64'(1) << pick));
                if (pick >= 0) last_owner = pick;
                beats = 0;
            end else if (rel != 1 && prev_valid != 0) begin
                chk("arb_missed", 64'(grant), 64'(1) << ((last_owner + 1) % N));
            end
            exit_pend = 1'b0;
            xfer_seen = in_valid & in_ready;
            if (xfer_seen != 0) begin
                src = 0;
                for (int c = 0; c < N; c++) if (xfer_seen[c]) src = c;
                q.push_back('{ch: CW'(src), dd: d[src], aa: a[src], ll: l[src]});
                beats++;
                exit_pend = l[src] || (beats == MB);
            end
            prev_grant = grant;
            prev_valid = in_valid;
            if (rel < 10) rel++;
        end
    end

    task automatic check_reset_outputs(string tag);
        chk({tag, "_grant"}, 64'(grant), 64'(0));
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(0));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({tag, "_out_regs"}, 64'({out_ch, out_addr, out_last, out_data}), 64'(0));
    endtask

    initial begin
        logic busy;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        mode = 1;
        repeat (300) @(posedge clk);
        mode = 3;
        repeat (5) @(posedge clk);
        mode = 1;
        repeat (300) @(posedge clk);
        busy = 1'b0;
        for (int i = 0; i < 200 && !busy; i++) begin
            @(posedge clk);
            busy = (grant != 0) && out_valid;
        end
        chk("midburst_found", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midburst_reset");
        mode = 2;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        mode = 1;
        repeat (300) @(posedge clk);
        mode = 4;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
